// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared widths, port encoding and beat layout for the enigma arbiter
package enigma_pkg;

  localparam int PLD_W   = 128;
  localparam int ID_W    = 5;
  localparam int QOS_W   = 2;
  localparam int AGE_MAX = 15;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } enigma_port_e;

  typedef struct packed {
    logic [PLD_W-1:0] payload;
    logic [ID_W-1:0]  id;
    logic [QOS_W-1:0] qos;
  } enigma_beat_t;

endpackage

// File: rtl/enigma_id_scoreboard.sv
// rtl/enigma_id_scoreboard.sv - held-ID bit vector with set/clear, two lookups and err_rel pulse
module enigma_id_scoreboard
  import enigma_pkg::*;
#(
  parameter int KEY_W = ID_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set_en,
  input  logic [KEY_W-1:0] i_set_key,
  input  logic             i_clr_en,
  input  logic [KEY_W-1:0] i_clr_key,
  input  logic [KEY_W-1:0] i_lkp_a_key,
  input  logic [KEY_W-1:0] i_lkp_b_key,
  output logic             o_held_a,
  output logic             o_held_b,
  output logic             o_err_rel
);

  localparam int N_KEYS = 1 << KEY_W;

  logic [N_KEYS-1:0] r_held;
  logic [N_KEYS-1:0] w_held_nxt;
  logic              r_err_rel;

  // Clear is applied first so a same-cycle set on the same key wins.
  always_comb begin
    w_held_nxt = r_held;
    if (i_clr_en) w_held_nxt[i_clr_key] = 1'b0;
    if (i_set_en) w_held_nxt[i_set_key] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_held    <= '0;
      r_err_rel <= 1'b0;
    end else begin
      r_held    <= w_held_nxt;
      r_err_rel <= i_clr_en && !r_held[i_clr_key];
    end
  end

  assign o_held_a  = r_held[i_lkp_a_key];
  assign o_held_b  = r_held[i_lkp_b_key];
  assign o_err_rel = r_err_rel;

endmodule

// File: rtl/enigma_qos_arb.sv
// rtl/enigma_qos_arb.sv - two-port QoS/round-robin arbiter onto port C; aging via ENIGMA_ARB_AGING_EN
module enigma_qos_arb
  import enigma_pkg::*;
#(
  parameter int PLD_W   = enigma_pkg::PLD_W,
  parameter int ID_W    = enigma_pkg::ID_W,
  parameter int QOS_W   = enigma_pkg::QOS_W,
  parameter int AGE_MAX = enigma_pkg::AGE_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PLD_W-1:0] payload_a,
  input  logic [ID_W-1:0]  id_a,
  input  logic [QOS_W-1:0] qos_a,
  input  logic             valid_a,
  output logic             ready_a,
  input  logic [PLD_W-1:0] payload_b,
  input  logic [ID_W-1:0]  id_b,
  input  logic [QOS_W-1:0] qos_b,
  input  logic             valid_b,
  output logic             ready_b,
  output logic [PLD_W-1:0] payload_c,
  output logic [ID_W:0]    id_c,
  output logic [QOS_W-1:0] qos_c,
  output logic             valid_c,
  input  logic             ready_c,
  input  logic             conflict_c,
  input  logic             release_c,
  input  logic [ID_W:0]    releaseid_c,
  output logic             err_rel
);

  localparam int KEY_W = ID_W + 1;

  logic [PLD_W-1:0] r_payload;
  logic [KEY_W-1:0] r_id;
  logic [QOS_W-1:0] r_qos;
  logic             r_valid;
  enigma_port_e     r_rr;

  logic [KEY_W-1:0] w_key_a;
  logic [KEY_W-1:0] w_key_b;
  logic             w_held_a;
  logic             w_held_b;
  logic             w_elig_a;
  logic             w_elig_b;
  logic             w_load;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_tie;
  logic             w_aged_a;
  logic             w_aged_b;

  assign w_key_a  = {PORT_A, id_a};
  assign w_key_b  = {PORT_B, id_b};
  assign w_elig_a = valid_a && !w_held_a;
  assign w_elig_b = valid_b && !w_held_b;
  assign w_load   = !r_valid || ready_c;

  enigma_id_scoreboard #(
    .KEY_W (KEY_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_en    (r_valid && ready_c && conflict_c),
    .i_set_key   (r_id),
    .i_clr_en    (release_c),
    .i_clr_key   (releaseid_c),
    .i_lkp_a_key (w_key_a),
    .i_lkp_b_key (w_key_b),
    .o_held_a    (w_held_a),
    .o_held_b    (w_held_b),
    .o_err_rel   (err_rel)
  );

`ifdef ENIGMA_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [AGE_W-1:0] r_age_a;
  logic [AGE_W-1:0] r_age_b;

  assign w_aged_a = w_elig_a && (r_age_a == AGE_W'(AGE_MAX));
  assign w_aged_b = w_elig_b && (r_age_b == AGE_W'(AGE_MAX));

  // Counts cycles a port was eligible but not granted, including output stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_age_a <= '0;
      r_age_b <= '0;
    end else begin
      if (ready_a)                                     r_age_a <= '0;
      else if (w_elig_a && r_age_a != AGE_W'(AGE_MAX)) r_age_a <= r_age_a + 1'b1;
      if (ready_b)                                     r_age_b <= '0;
      else if (w_elig_b && r_age_b != AGE_W'(AGE_MAX)) r_age_b <= r_age_b + 1'b1;
    end
  end
`else
  logic w_unused_age;
  assign w_unused_age = (AGE_MAX > 0);
  assign w_aged_a     = 1'b0;
  assign w_aged_b     = 1'b0;
`endif

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    w_tie     = 1'b0;
    if (w_elig_a && !w_elig_b) begin
      w_grant_a = 1'b1;
    end else if (w_elig_b && !w_elig_a) begin
      w_grant_b = 1'b1;
    end else if (w_elig_a && w_elig_b) begin
      if (w_aged_a != w_aged_b) begin
        w_grant_a = w_aged_a;
        w_grant_b = w_aged_b;
      end else if (!w_aged_a && qos_a > qos_b) begin
        w_grant_a = 1'b1;
      end else if (!w_aged_a && qos_b > qos_a) begin
        w_grant_b = 1'b1;
      end else begin
        w_tie     = 1'b1;
        w_grant_a = (r_rr == PORT_A);
        w_grant_b = (r_rr == PORT_B);
      end
    end
  end

  assign ready_a = w_load && w_grant_a && rst_n;
  assign ready_b = w_load && w_grant_b && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_id      <= '0;
      r_qos     <= '0;
      r_rr      <= PORT_A;
    end else if (w_load) begin
      r_valid <= w_grant_a || w_grant_b;
      if (w_grant_a) begin
        r_payload <= payload_a;
        r_id      <= w_key_a;
        r_qos     <= qos_a;
      end else if (w_grant_b) begin
        r_payload <= payload_b;
        r_id      <= w_key_b;
        r_qos     <= qos_b;
      end
      if (w_tie) r_rr <= (r_rr == PORT_A) ? PORT_B : PORT_A;
    end
  end

  assign valid_c   = r_valid;
  assign payload_c = r_payload;
  assign id_c      = r_id;
  assign qos_c     = r_qos;

endmodule

// File: tb/tb_enigma_qos_arb.sv
// tb/tb_enigma_qos_arb.sv - vector table plus hand sequences with a beat scoreboard on port C
module tb_enigma_qos_arb;
  import enigma_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [PLD_W-1:0] payload_a, payload_b;
  logic [ID_W-1:0]  id_a, id_b;
  logic [QOS_W-1:0] qos_a, qos_b;
  logic             valid_a, valid_b, ready_a, ready_b;
  logic [PLD_W-1:0] payload_c;
  logic [ID_W:0]    id_c;
  logic [QOS_W-1:0] qos_c;
  logic             valid_c, ready_c, conflict_c, release_c, err_rel;
  logic [ID_W:0]    releaseid_c;

  enigma_qos_arb dut (
    .clk(clk), .rst_n(rst_n),
    .payload_a(payload_a), .id_a(id_a), .qos_a(qos_a), .valid_a(valid_a), .ready_a(ready_a),
    .payload_b(payload_b), .id_b(id_b), .qos_b(qos_b), .valid_b(valid_b), .ready_b(ready_b),
    .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c), .valid_c(valid_c), .ready_c(ready_c),
    .conflict_c(conflict_c), .release_c(release_c), .releaseid_c(releaseid_c), .err_rel(err_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             va;
    logic [QOS_W-1:0] qa;
    logic [ID_W-1:0]  ia;
    logic             vb;
    logic [QOS_W-1:0] qb;
    logic [ID_W-1:0]  ib;
    logic             rc;
    logic             era, erb, evc;
  } vec_t;

  typedef struct packed {
    enigma_port_e port;
    enigma_beat_t beat;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    check(nm, 160'(act), 160'(exp));
  endtask

  task automatic add(input int va, qa, ia, vb, qb, ib, rc, era, erb, evc);
    vec_t v;
    v.va = 1'(va); v.qa = QOS_W'(qa); v.ia = ID_W'(ia);
    v.vb = 1'(vb); v.qb = QOS_W'(qb); v.ib = ID_W'(ib);
    v.rc = 1'(rc); v.era = 1'(era); v.erb = 1'(erb); v.evc = 1'(evc);
    tbl.push_back(v);
  endtask

  task automatic drive(input int va, qa, ia, vb, qb, ib, rc, cf, rel, relid);
    valid_a = 1'(va); qos_a = QOS_W'(qa); id_a = ID_W'(ia);
    valid_b = 1'(vb); qos_b = QOS_W'(qb); id_b = ID_W'(ib);
    ready_c = 1'(rc); conflict_c = 1'(cf); release_c = 1'(rel); releaseid_c = (ID_W+1)'(relid);
    payload_a = {$urandom, $urandom, $urandom, $urandom};
    payload_b = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every beat seen on C must match the oldest accepted beat; stalled beats are rechecked each cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (valid_c) begin
        if (exp_q.size() == 0) begin
          chk1("c_beat_expected", valid_c, 1'b0);
        end else begin
          check("c_beat", 160'({id_c, qos_c, payload_c}),
                160'({exp_q[0].port, exp_q[0].beat.id, exp_q[0].beat.qos, exp_q[0].beat.payload}));
          if (ready_c) void'(exp_q.pop_front());
        end
      end
      if (ready_a) exp_q.push_back('{PORT_A, '{payload_a, id_a, qos_a}});
      if (ready_b) exp_q.push_back('{PORT_B, '{payload_b, id_b, qos_b}});
    end
  end

  int found;
  int exp_first;

  initial begin
    rst_n = 1'b0;
    drive(1, 2, 1, 1, 2, 2, 1, 0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    chk1("rst_ready_a", ready_a, 1'b0);
    chk1("rst_ready_b", ready_b, 1'b0);
    chk1("rst_valid_c", valid_c, 1'b0);
    chk1("rst_err_rel", err_rel, 1'b0);
    tick();
    rst_n = 1'b1;

    // va qa ia vb qb ib rc | ready_a ready_b valid_c
    add(1, 2, 1, 1, 2, 2, 1, 1, 0, 0);
    add(1, 2, 1, 1, 2, 2, 1, 0, 1, 1);
    add(1, 2, 1, 1, 2, 2, 1, 1, 0, 1);
    add(1, 2, 1, 1, 2, 2, 1, 0, 1, 1);
    add(1, 3, 4, 1, 1, 5, 1, 1, 0, 1);
    add(1, 3, 4, 1, 1, 5, 1, 1, 0, 1);
    add(1, 3, 4, 1, 1, 5, 1, 1, 0, 1);
    add(1, 3, 4, 1, 1, 5, 1, 1, 0, 1);
    add(0, 3, 4, 1, 1, 5, 1, 0, 1, 1);
    add(1, 0, 6, 1, 0, 7, 1, 1, 0, 1);
    add(1, 0, 6, 0, 3, 7, 1, 1, 0, 1);
    add(1, 1, 8, 1, 1, 9, 1, 0, 1, 1);
    add(1, 1, 8, 1, 1, 9, 0, 0, 0, 1);
    add(1, 1, 8, 1, 1, 9, 0, 0, 0, 1);
    add(1, 1, 8, 1, 1, 9, 0, 0, 0, 1);
    add(1, 1, 8, 1, 1, 9, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].va, tbl[i].qa, tbl[i].ia, tbl[i].vb, tbl[i].qb, tbl[i].ib, tbl[i].rc, 0, 0, 0);
      @(negedge clk);
      check($sformatf("vec%0d_ready_a", i), 160'(ready_a), 160'(tbl[i].era));
      check($sformatf("vec%0d_ready_b", i), 160'(ready_b), 160'(tbl[i].erb));
      check($sformatf("vec%0d_valid_c", i), 160'(valid_c), 160'(tbl[i].evc));
      tick();
    end

    // Hold on B id 3 (id_c 0x23), release it, then a release of an idle ID.
    drive(0, 0, 0, 1, 1, 3, 1, 0, 0, 0);
    @(negedge clk); chk1("hold_first_acc", ready_b, 1'b1); tick();
    drive(0, 0, 0, 1, 1, 3, 1, 1, 0, 0);
    @(negedge clk);
    check("hold_id_c", 160'(id_c), 160'(6'h23));
    chk1("hold_same_cycle_acc", ready_b, 1'b1);
    tick();
    drive(0, 0, 0, 1, 1, 3, 1, 0, 0, 0);
    @(negedge clk); chk1("hold_blocked", ready_b, 1'b0); tick();
    drive(1, 0, 3, 1, 1, 3, 1, 0, 0, 0);
    @(negedge clk);
    chk1("hold_blocked_b_only", ready_b, 1'b0);
    chk1("hold_a_same_id_free", ready_a, 1'b1);
    tick();
    drive(0, 0, 0, 1, 1, 3, 1, 0, 0, 0);
    @(negedge clk); chk1("hold_still_blocked", ready_b, 1'b0); tick();
    drive(0, 0, 0, 1, 1, 3, 1, 0, 1, 'h23);
    @(negedge clk); chk1("rel_cycle_blocked", ready_b, 1'b0); tick();
    drive(0, 0, 0, 1, 1, 3, 1, 0, 0, 0);
    @(negedge clk);
    chk1("rel_unblocked", ready_b, 1'b1);
    chk1("rel_valid_no_err", err_rel, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk); check("rel_beat_on_c", 160'({valid_c, id_c}), 160'({1'b1, 6'h23})); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 'h05);
    @(negedge clk); chk1("err_before", err_rel, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk); chk1("err_pulse", err_rel, 1'b1); tick();
    @(negedge clk); chk1("err_one_cycle", err_rel, 1'b0); tick();

    // Set and release of the same ID in one cycle: the hold survives.
    drive(0, 0, 0, 1, 2, 7, 1, 0, 0, 0);
    @(negedge clk); chk1("sw_acc", ready_b, 1'b1); tick();
    drive(0, 0, 0, 1, 2, 7, 1, 1, 1, 'h27);
    @(negedge clk); check("sw_id_c", 160'({valid_c, id_c}), 160'({1'b1, 6'h27})); tick();
    drive(0, 0, 0, 1, 2, 7, 1, 0, 0, 0);
    @(negedge clk);
    chk1("sw_set_wins", ready_b, 1'b0);
    chk1("sw_err_rel", err_rel, 1'b1);
    chk1("sw_pending_beat", valid_c, 1'b1);
    tick();

    // Reset with a beat pending on C and an ID held.
    rst_n = 1'b0;
    @(negedge clk); chk1("midrst_ready_b", ready_b, 1'b0); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("midrst_drop", valid_c, 1'b0);
    chk1("midrst_holds_lost", ready_b, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef ENIGMA_ARB_AGING_EN
    exp_first = 16;
`else
    exp_first = 0;
`endif
    found = 0;
    for (int c = 1; c <= 40; c++) begin
      drive(1, 3, 1, 1, 0, 2, 1, 0, 0, 0);
      @(negedge clk);
      if (ready_b && found == 0) found = c;
      tick();
    end
    check("aging_first_b_grant", 160'(found), 160'(exp_first));

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (3) tick();
    @(negedge clk);
    check("q_drained", 160'(exp_q.size()), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
